// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush (CLR) and reset.
// Define PIPE_STAGE_SKID_BUF_EN to add a skid entry so in_ready never depends on out_ready.
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter bit CLR_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic              mainValid_q, mainValid_d;
  logic [DATA_W-1:0] mainData_q, mainData_d;
  logic              inXfer, outXfer;

  assign out_valid = mainValid_q;
  assign out_data  = mainData_q;
  assign inXfer    = in_valid && in_ready;
  assign outXfer   = mainValid_q && out_ready;

`ifdef PIPE_STAGE_SKID_BUF_EN

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic              skidValid_q, skidValid_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;

  // Ready comes from a flop only, which breaks the combinational ready chain upstream.
  assign in_ready = !CLR && !skidValid_q;
  assign level    = skidValid_q ? 2'd2 : {1'b0, mainValid_q};

  always_comb begin
    state_d     = state_q;
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (CLR) begin
      state_d     = EMPTY;
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
      if (CLR_ZERO) begin
        mainData_d = '0;
        skidData_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (inXfer) begin
            state_d     = ONE;
            mainValid_d = 1'b1;
            mainData_d  = in_data;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainData_d = in_data;
          end else if (inXfer) begin
            state_d     = FULL;
            skidValid_d = 1'b1;
            skidData_d  = in_data;
          end else if (outXfer) begin
            state_d     = EMPTY;
            mainValid_d = 1'b0;
          end
        end
        FULL: begin
          if (outXfer) begin
            state_d     = ONE;
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
          end
        end
        default: begin
          state_d     = EMPTY;
          mainValid_d = 1'b0;
          skidValid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      state_q     <= state_d;
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end

`else

  // A full stage can still accept when the downstream drains it on the same edge.
  assign in_ready = !CLR && (!mainValid_q || out_ready);
  assign level    = {1'b0, mainValid_q};

  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    if (CLR) begin
      mainValid_d = 1'b0;
      if (CLR_ZERO) begin
        mainData_d = '0;
      end
    end else if (inXfer) begin
      mainValid_d = 1'b1;
      mainData_d  = in_data;
    end else if (outXfer) begin
      mainValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
    end
  end

`endif

endmodule
